// File: rtl/bcd_input_counter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module      : bcd_input_counter (with debounce sub-module)
// Description : Synchronised, debounced inc/dec pushbuttons driving a 4-bit
//               wrapping count with synchronous switch preset.
// Revision    : 1.0 - initial release
// -----------------------------------------------------------------------------

module bcd_input_counter_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pressed,
    output logic o_event
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The event fires on the edge that qualifies the press; holding gives no repeat.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_event     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_pressed) begin
                    w_state_nxt = S_PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            S_PRESS_WAIT: begin
                if (!i_pressed) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == C_LAST) begin
                    w_state_nxt = S_PRESSED;
                    o_event     = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_PRESSED: begin
                if (!i_pressed) begin
                    w_state_nxt = S_RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            S_RELEASE_WAIT: begin
                if (i_pressed) begin
                    w_state_nxt = S_PRESSED;
                end else if (r_cnt == C_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end
endmodule

module bcd_input_counter #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_inc_n,
    input  logic       btn_dec_n,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] x,
    output logic       wrap
);
    logic [1:0] r_inc_sync;
    logic [1:0] r_dec_sync;
    logic [1:0] r_load_sync;
    logic [1:0] w_pressed;
    logic [1:0] w_event;
    logic [3:0] r_x;
    logic       r_wrap;

    // Synchronisers reset to the released level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inc_sync  <= 2'b11;
            r_dec_sync  <= 2'b11;
            r_load_sync <= 2'b00;
        end else begin
            r_inc_sync  <= {r_inc_sync[0], btn_inc_n};
            r_dec_sync  <= {r_dec_sync[0], btn_dec_n};
            r_load_sync <= {r_load_sync[0], load};
        end
    end

    assign w_pressed = {~r_dec_sync[1], ~r_inc_sync[1]};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            bcd_input_counter_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk       (clk),
                .rst_n     (rst_n),
                .i_pressed (w_pressed[gi]),
                .o_event   (w_event[gi])
            );
        end
    endgenerate

    // Bit 0 of w_event is increment, bit 1 is decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= 4'd0;
            r_wrap <= 1'b0;
        end else if (r_load_sync[1]) begin
            r_x    <= load_val;
            r_wrap <= 1'b0;
        end else begin
            case (w_event)
                2'b01: begin
                    r_x    <= r_x + 4'd1;
                    r_wrap <= (r_x == 4'd15);
                end
                2'b10: begin
                    r_x    <= r_x - 4'd1;
                    r_wrap <= (r_x == 4'd0);
                end
                default: begin
                    r_wrap <= 1'b0;
                end
            endcase
        end
    end

    assign x    = r_x;
    assign wrap = r_wrap;
endmodule

`default_nettype wire

// File: tb/tb_bcd_input_counter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module      : tb_bcd_input_counter
// Description : Self-checking bench: segment table, hand sequences, random run.
// Revision    : 1.0 - initial release
// -----------------------------------------------------------------------------
module tb_bcd_input_counter;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_inc_n = 1'b1;
    logic       btn_dec_n = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] x;
    logic       wrap;

    bcd_input_counter #(.DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_inc_n (btn_inc_n),
        .btn_dec_n (btn_dec_n),
        .load      (load),
        .load_val  (load_val),
        .x         (x),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: input delay line plus run-length press qualification.
    bit q_inc[2];
    bit q_dec[2];
    bit q_ld[2];
    int lo_run[2];
    int hi_run[2];
    bit armed[2];
    int mx;
    bit mw;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            q_inc[i] = 1'b1; q_dec[i] = 1'b1; q_ld[i] = 1'b0;
            lo_run[i] = 0; hi_run[i] = 0; armed[i] = 1'b1;
        end
        mx = 0;
        mw = 1'b0;
    endtask

    task automatic model_edge();
        bit pr[2];
        bit ev[2];
        bit ldv;
        pr[0] = !q_inc[1];
        pr[1] = !q_dec[1];
        ldv   = q_ld[1];
        for (int b = 0; b < 2; b++) begin
            if (pr[b]) begin
                lo_run[b]++; hi_run[b] = 0;
            end else begin
                hi_run[b]++; lo_run[b] = 0;
            end
            ev[b] = 1'b0;
            if (armed[b] && lo_run[b] == D + 1) begin
                ev[b] = 1'b1; armed[b] = 1'b0;
            end else if (!armed[b] && hi_run[b] == D + 1) begin
                armed[b] = 1'b1;
            end
        end
        if (ldv) begin
            mx = int'(load_val); mw = 1'b0;
        end else if (ev[0] && !ev[1]) begin
            mw = (mx == 15); mx = (mx + 1) % 16;
        end else if (ev[1] && !ev[0]) begin
            mw = (mx == 0); mx = (mx + 15) % 16;
        end else begin
            mw = 1'b0;
        end
        q_inc[1] = q_inc[0]; q_inc[0] = btn_inc_n;
        q_dec[1] = q_dec[0]; q_dec[0] = btn_dec_n;
        q_ld[1]  = q_ld[0];  q_ld[0]  = load;
    endtask

    task automatic hcheck(input string name, input logic [3:0] ex, input logic ew);
        n_vec++;
        if (x !== ex || wrap !== ew) begin
            n_err++;
            $display("FAIL %s @%0t: got x=%0d wrap=%b, required x=%0d wrap=%b",
                     name, $time, x, wrap, ex, ew);
        end
    endtask

    task automatic step(input string name);
        @(posedge clk);
        model_edge();
        #1;
        hcheck(name, mx[3:0], mw);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        hcheck("reset_state", 4'd0, 1'b0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit         rst;
        bit         inc_n;
        bit         dec_n;
        bit         ld;
        logic [3:0] lv;
        int         n;
        logic [3:0] ex;
        bit         ew;
    } seg_t;

    function automatic seg_t mk(int rst, int inc, int dec, int ld, int lv, int n, int ex, int ew);
        seg_t s;
        s.rst = rst[0]; s.inc_n = inc[0]; s.dec_n = dec[0]; s.ld = ld[0];
        s.lv = lv[3:0]; s.n = n; s.ex = ex[3:0]; s.ew = ew[0];
        return s;
    endfunction

    seg_t tbl[31];

    initial begin
        // rst, inc_n, dec_n, load, load_val, cycles, expected x, expected wrap
        tbl[0]  = mk(1, 0, 1, 0, 0, 6, 0, 0);
        tbl[1]  = mk(0, 0, 1, 0, 0, 1, 1, 0);
        tbl[2]  = mk(0, 0, 1, 0, 0, 13, 1, 0);
        tbl[3]  = mk(0, 1, 1, 0, 0, 10, 1, 0);
        tbl[4]  = mk(1, 0, 1, 0, 0, 3, 0, 0);
        tbl[5]  = mk(0, 1, 1, 0, 0, 3, 0, 0);
        tbl[6]  = mk(0, 0, 1, 0, 0, 3, 0, 0);
        tbl[7]  = mk(0, 1, 1, 0, 0, 3, 0, 0);
        tbl[8]  = mk(0, 0, 1, 0, 0, 3, 0, 0);
        tbl[9]  = mk(0, 1, 1, 0, 0, 10, 0, 0);
        tbl[10] = mk(1, 1, 1, 1, 15, 3, 15, 0);
        tbl[11] = mk(0, 1, 1, 0, 15, 3, 15, 0);
        tbl[12] = mk(0, 0, 1, 0, 15, 7, 0, 1);
        tbl[13] = mk(0, 0, 1, 0, 15, 1, 0, 0);
        tbl[14] = mk(0, 1, 1, 0, 15, 10, 0, 0);
        tbl[15] = mk(0, 1, 0, 0, 15, 7, 15, 1);
        tbl[16] = mk(0, 1, 0, 0, 15, 1, 15, 0);
        tbl[17] = mk(0, 1, 1, 0, 15, 10, 15, 0);
        tbl[18] = mk(1, 0, 1, 0, 0, 8, 1, 0);
        tbl[19] = mk(0, 1, 1, 0, 0, 2, 1, 0);
        tbl[20] = mk(0, 0, 1, 0, 0, 2, 1, 0);
        tbl[21] = mk(0, 1, 1, 0, 0, 2, 1, 0);
        tbl[22] = mk(0, 0, 1, 0, 0, 2, 1, 0);
        tbl[23] = mk(0, 1, 1, 0, 0, 10, 1, 0);
        tbl[24] = mk(0, 0, 1, 0, 0, 7, 2, 0);
        tbl[25] = mk(0, 1, 1, 0, 0, 10, 2, 0);
        tbl[26] = mk(1, 0, 0, 0, 0, 7, 0, 0);
        tbl[27] = mk(0, 0, 0, 0, 0, 5, 0, 0);
        tbl[28] = mk(0, 1, 1, 0, 0, 10, 0, 0);
        tbl[29] = mk(0, 0, 1, 1, 9, 7, 9, 0);
        tbl[30] = mk(0, 1, 1, 0, 9, 10, 9, 0);

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 31; i++) begin
            if (tbl[i].rst) begin
                btn_inc_n = 1'b1; btn_dec_n = 1'b1; load = 1'b0;
                do_reset();
            end
            btn_inc_n = tbl[i].inc_n;
            btn_dec_n = tbl[i].dec_n;
            load      = tbl[i].ld;
            load_val  = tbl[i].lv;
            repeat (tbl[i].n) step($sformatf("seg%0d_cycle", i));
            hcheck($sformatf("seg%0d_end", i), tbl[i].ex, tbl[i].ew);
        end

        // Asynchronous reset in the middle of a press qualification.
        do_reset();
        load = 1'b1; load_val = 4'd5;
        repeat (3) step("rst6_load");
        load = 1'b0;
        repeat (3) step("rst6_hold");
        btn_inc_n = 1'b0;
        repeat (5) step("rst6_press");
        hcheck("rst6_before", 4'd5, 1'b0);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        hcheck("rst6_async", 4'd0, 1'b0);
        #2;
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step("rst6_after");
            hcheck($sformatf("rst6_edge%0d", i), (i >= D + 3) ? 4'd1 : 4'd0, 1'b0);
        end
        btn_inc_n = 1'b1;
        repeat (10) step("rst6_release");

        // Randomized run against the model.
        for (int k = 0; k < 90; k++) begin
            int len;
            btn_inc_n = 1'($urandom_range(0, 1));
            btn_dec_n = 1'($urandom_range(0, 1));
            load      = ($urandom_range(0, 7) == 0);
            load_val  = 4'($urandom_range(0, 15));
            len       = $urandom_range(1, 14);
            repeat (len) step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
